// File: rtl/sixteen_bit_1x16_demux_reg.sv
// Registered 1-to-16 demux for 16-bit words: writes land in a shadow bank and
// all 16 outputs update together on a commit (explicit or end-of-frame auto).
module sixteen_bit_1x16_demux_reg #(
  parameter bit AUTO_COMMIT = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  input  logic [3:0]  i_select,
  input  logic        i_auto,
  input  logic        i_commit,
  input  logic        i_clear,
  output logic [15:0] o_0,
  output logic [15:0] o_1,
  output logic [15:0] o_2,
  output logic [15:0] o_3,
  output logic [15:0] o_4,
  output logic [15:0] o_5,
  output logic [15:0] o_6,
  output logic [15:0] o_7,
  output logic [15:0] o_8,
  output logic [15:0] o_9,
  output logic [15:0] o_A,
  output logic [15:0] o_B,
  output logic [15:0] o_C,
  output logic [15:0] o_D,
  output logic [15:0] o_E,
  output logic [15:0] o_F,
  output logic [3:0]  o_pointer,
  output logic        o_frame
);

  logic [15:0] shadow_q [16];
  logic [15:0] shadow_d [16];
  logic [15:0] out_q    [16];
  logic [15:0] out_d    [16];
  logic [3:0]  ptr_q, ptr_d;
  logic        frame_q, frame_d;

  logic [3:0]  slot;
  logic        auto_commit;
  logic        commit;

  assign slot        = i_auto ? ptr_q : i_select;
  assign auto_commit = AUTO_COMMIT && i_auto && i_valid && (ptr_q == 4'hF);
  assign commit      = i_commit || auto_commit;

  // NOTE: every variable gets a default at the top of always_comb; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    shadow_d = shadow_q;
    out_d    = out_q;
    ptr_d    = ptr_q;
    frame_d  = 1'b0;

    if (i_clear) begin
      for (int n = 0; n < 16; n++) begin
        shadow_d[n] = '0;
        out_d[n]    = '0;
      end
      ptr_d = '0;
    end else begin
      if (i_valid) begin
        shadow_d[slot] = i_data;
        if (i_auto) ptr_d = ptr_q + 4'd1;
      end
      // Commit copies the post-write shadow so a same-cycle write goes through.
      if (commit) out_d = shadow_d;
      frame_d = auto_commit;
    end
  end

  // NOTE: both banks are plain registers and are reset like any other state so
  // a reset mid-frame cannot leak stale words into a later commit; non-blocking
  // assignments keep every register sampling the pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int n = 0; n < 16; n++) begin
        shadow_q[n] <= '0;
        out_q[n]    <= '0;
      end
      ptr_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
      ptr_q    <= ptr_d;
      frame_q  <= frame_d;
    end
  end

  assign o_0       = out_q[0];
  assign o_1       = out_q[1];
  assign o_2       = out_q[2];
  assign o_3       = out_q[3];
  assign o_4       = out_q[4];
  assign o_5       = out_q[5];
  assign o_6       = out_q[6];
  assign o_7       = out_q[7];
  assign o_8       = out_q[8];
  assign o_9       = out_q[9];
  assign o_A       = out_q[10];
  assign o_B       = out_q[11];
  assign o_C       = out_q[12];
  assign o_D       = out_q[13];
  assign o_E       = out_q[14];
  assign o_F       = out_q[15];
  assign o_pointer = ptr_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_sixteen_bit_1x16_demux_reg.sv
// Directed bench: one instance with auto-commit, one without, sharing stimulus.
module tb_sixteen_bit_1x16_demux_reg;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_data;
  logic        i_valid;
  logic [3:0]  i_select;
  logic        i_auto;
  logic        i_commit;
  logic        i_clear;

  logic [15:0] o1 [16];
  logic [15:0] o2 [16];
  logic [3:0]  ptr1, ptr2;
  logic        frame1, frame2;

  logic [15:0] exp1 [16];
  logic [15:0] exp2 [16];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  sixteen_bit_1x16_demux_reg #(.AUTO_COMMIT(1'b1)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .i_select(i_select), .i_auto(i_auto), .i_commit(i_commit), .i_clear(i_clear),
    .o_0(o1[0]),   .o_1(o1[1]),   .o_2(o1[2]),   .o_3(o1[3]),
    .o_4(o1[4]),   .o_5(o1[5]),   .o_6(o1[6]),   .o_7(o1[7]),
    .o_8(o1[8]),   .o_9(o1[9]),   .o_A(o1[10]),  .o_B(o1[11]),
    .o_C(o1[12]),  .o_D(o1[13]),  .o_E(o1[14]),  .o_F(o1[15]),
    .o_pointer(ptr1), .o_frame(frame1)
  );

  sixteen_bit_1x16_demux_reg #(.AUTO_COMMIT(1'b0)) dut_nc (
    .i_clock(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .i_select(i_select), .i_auto(i_auto), .i_commit(i_commit), .i_clear(i_clear),
    .o_0(o2[0]),   .o_1(o2[1]),   .o_2(o2[2]),   .o_3(o2[3]),
    .o_4(o2[4]),   .o_5(o2[5]),   .o_6(o2[6]),   .o_7(o2[7]),
    .o_8(o2[8]),   .o_9(o2[9]),   .o_A(o2[10]),  .o_B(o2[11]),
    .o_C(o2[12]),  .o_D(o2[13]),  .o_E(o2[14]),  .o_F(o2[15]),
    .o_pointer(ptr2), .o_frame(frame2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_bank1(input string tag);
    for (int n = 0; n < 16; n++)
      check($sformatf("%s o1[%0d]", tag, n), o1[n], exp1[n]);
  endtask

  task automatic check_bank2(input string tag);
    for (int n = 0; n < 16; n++)
      check($sformatf("%s o2[%0d]", tag, n), o2[n], exp2[n]);
  endtask

  task automatic idle_inputs();
    i_valid  = 1'b0;
    i_commit = 1'b0;
    i_clear  = 1'b0;
    i_auto   = 1'b0;
    i_select = 4'h0;
    i_data   = 16'h0000;
  endtask

  initial begin
    idle_inputs();
    for (int n = 0; n < 16; n++) begin
      exp1[n] = '0;
      exp2[n] = '0;
    end

    // Reset state
    i_reset = 1'b1;
    #12;
    i_reset = 1'b0;
    tick();
    check_bank1("reset");
    check("reset ptr", {12'd0, ptr1}, 16'd0);
    check("reset frame", {15'd0, frame1}, 16'd0);

    // Load something, then assert reset asynchronously mid-cycle
    i_valid = 1'b1; i_select = 4'h7; i_data = 16'hAAAA; i_commit = 1'b1;
    tick();
    check("pre-reset o7", o1[7], 16'hAAAA);
    i_commit = 1'b0; i_auto = 1'b1; i_data = 16'h0101;
    tick();
    check("pre-reset ptr", {12'd0, ptr1}, 16'd1);
    idle_inputs();
    #3;
    i_reset = 1'b1;
    #1;
    check_bank1("async reset");
    check("async reset ptr", {12'd0, ptr1}, 16'd0);
    #1;
    i_reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("idle %0d o7", c), o1[7], 16'h0000);
      check($sformatf("idle %0d frame", c), {15'd0, frame1}, 16'd0);
    end
    check_bank1("after idle");
    check("after idle ptr", {12'd0, ptr1}, 16'd0);

    // Auto frame load: outputs hold until the 16th write commits the frame
    i_auto = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] nib;
      nib = k[3:0];
      i_data = {nib, nib, nib, nib};
      tick();
      if (k < 15) begin
        check_bank1($sformatf("auto wr%0d", k));
        check($sformatf("auto wr%0d ptr", k), {12'd0, ptr1}, 16'(k + 1));
        check($sformatf("auto wr%0d frame", k), {15'd0, frame1}, 16'd0);
      end
    end
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nib;
      nib = n[3:0];
      exp1[n] = {nib, nib, nib, nib};
    end
    check_bank1("frame commit");
    check("frame pulse", {15'd0, frame1}, 16'd1);
    check("frame ptr wrap", {12'd0, ptr1}, 16'd0);
    check("no-autocommit frame", {15'd0, frame2}, 16'd0);
    idle_inputs();
    tick();
    check("frame pulse end", {15'd0, frame1}, 16'd0);
    check_bank1("frame hold");

    // Addressed write, then explicit commit
    i_valid = 1'b1; i_select = 4'h5; i_data = 16'h1234;
    tick();
    check("addr wr o5 held", o1[5], 16'h5555);
    check("addr wr ptr kept", {12'd0, ptr1}, 16'd0);
    i_valid = 1'b0; i_commit = 1'b1;
    tick();
    exp1[5] = 16'h1234;
    check_bank1("explicit commit");
    check("explicit commit frame", {15'd0, frame1}, 16'd0);

    // Write-through commit
    i_valid = 1'b1; i_select = 4'h3; i_data = 16'hBEEF; i_commit = 1'b1;
    tick();
    exp1[3] = 16'hBEEF;
    check_bank1("write-through");
    check("write-through frame", {15'd0, frame1}, 16'd0);

    // Clear overrides simultaneous write and commit
    idle_inputs();
    i_auto = 1'b1; i_valid = 1'b1; i_data = 16'h7777;
    tick();
    check("pre-clear ptr", {12'd0, ptr1}, 16'd1);
    check_bank1("pre-clear hold");
    i_auto = 1'b0; i_select = 4'hF; i_data = 16'h9999; i_commit = 1'b1; i_clear = 1'b1;
    tick();
    for (int n = 0; n < 16; n++) exp1[n] = '0;
    check_bank1("clear");
    check("clear ptr", {12'd0, ptr1}, 16'd0);
    check("clear frame", {15'd0, frame1}, 16'd0);
    idle_inputs();
    i_commit = 1'b1;
    tick();
    check_bank1("post-clear commit");
    check("post-clear oF", o1[15], 16'h0000);

    // Pointer wrap without auto-commit
    idle_inputs();
    i_reset = 1'b1;
    #2;
    i_reset = 1'b0;
    i_auto = 1'b1; i_valid = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      i_data = 16'(i);
      tick();
      check($sformatf("wrap wr%0d frame", i), {15'd0, frame2}, 16'd0);
      if (i == 16) check("wrap autocommit frame", {15'd0, frame1}, 16'd1);
    end
    check("wrap ptr", {12'd0, ptr2}, 16'd2);
    check_bank2("wrap no commit");
    idle_inputs();
    i_commit = 1'b1;
    tick();
    exp2[0] = 16'd17;
    exp2[1] = 16'd18;
    for (int n = 2; n < 16; n++) exp2[n] = 16'(n + 1);
    check_bank2("wrap commit");
    check("wrap commit frame", {15'd0, frame2}, 16'd0);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
